// File: rtl/digital_in_if.sv
// Bus-slave interface for the digital_in peripheral: write data, write enable and read data.
interface digital_in_if;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;

  modport master (
    output WD,
    output WE,
    input  RD
  );

  modport slave (
    input  WD,
    input  WE,
    output RD
  );
endinterface

// File: rtl/digital_in.sv
// Digital input peripheral: 2-flop sync, per-bit debounce, sticky W1C edge flags, irq.
// Define DIGITAL_IN_FALL_EDGE_EN to add falling-edge flags at RD[16+N_IN-1:16].
module digital_in #(
  parameter int unsigned N_IN            = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] pins,
  digital_in_if.slave     bus,
  output logic            irq
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]            sync1_q, sync2_q;
  logic [N_IN-1:0]            state_q, state_d;
  logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]            rise;
  logic [N_IN-1:0]            clr_rise;
  logic [N_IN-1:0]            rise_flag_q, rise_flag_d;
  logic [31:0]                rd;
  logic                       unused_wd;

  // Only WD bits belonging to a clear field matter; the rest are intentionally ignored.
  assign unused_wd = ^bus.WD;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
    end
  end

  // A level is accepted once it has differed from state for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_IN; i++) begin
      if (sync2_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        state_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Edge detect on the next state so the flag sets on the same edge as the state update.
  assign rise     = state_d & ~state_q;
  assign clr_rise = bus.WE ? bus.WD[8 +: N_IN] : '0;

  always_comb begin
    rise_flag_d = (rise_flag_q & ~clr_rise) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_flag_q <= '0;
    end else begin
      rise_flag_q <= rise_flag_d;
    end
  end

`ifdef DIGITAL_IN_FALL_EDGE_EN
  logic [N_IN-1:0] fall;
  logic [N_IN-1:0] clr_fall;
  logic [N_IN-1:0] fall_flag_q, fall_flag_d;

  assign fall     = ~state_d & state_q;
  assign clr_fall = bus.WE ? bus.WD[16 +: N_IN] : '0;

  always_comb begin
    fall_flag_d = (fall_flag_q & ~clr_fall) | fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fall_flag_q <= '0;
    end else begin
      fall_flag_q <= fall_flag_d;
    end
  end

  always_comb begin
    rd             = '0;
    rd[N_IN-1:0]   = state_q;
    rd[8 +: N_IN]  = rise_flag_q;
    rd[16 +: N_IN] = fall_flag_q;
    irq            = (|rise_flag_q) | (|fall_flag_q);
  end
`else
  always_comb begin
    rd            = '0;
    rd[N_IN-1:0]  = state_q;
    rd[8 +: N_IN] = rise_flag_q;
    irq           = |rise_flag_q;
  end
`endif

  assign bus.RD = rd;

endmodule

// File: tb/tb_digital_in.sv
// Self-checking bench for digital_in: directed scenarios plus randomized pins/writes/resets.
module tb_digital_in;
  localparam int unsigned N = 5;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pins;
  logic         irq;

  digital_in_if bus_if ();

  digital_in #(
    .N_IN           (N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pins(pins),
    .bus (bus_if),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a level is accepted when the last D synchronized samples all oppose state.
  logic [N-1:0] pipe_q[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] m_state, m_rflag, m_fflag;

  function automatic logic [31:0] exp_rd();
    logic [31:0] v;
    v = '0;
    v[N-1:0] = m_state;
    v[8 +: N] = m_rflag;
`ifdef DIGITAL_IN_FALL_EDGE_EN
    v[16 +: N] = m_fflag;
`endif
    return v;
  endfunction

  function automatic logic exp_irq();
`ifdef DIGITAL_IN_FALL_EDGE_EN
    return (|m_rflag) | (|m_fflag);
`else
    return |m_rflag;
`endif
  endfunction

  task automatic model_edge(input logic [N-1:0] p, input logic we_v, input logic [31:0] wd_v,
                            input logic rst_v);
    logic [N-1:0] s2, nxt, clr_r, clr_f;
    logic         all_diff;
    if (rst_v) begin
      pipe_q.delete();
      pipe_q.push_back('0);
      pipe_q.push_back('0);
      hist.delete();
      for (int k = 0; k < D; k++) hist.push_back('0);
      m_state = '0;
      m_rflag = '0;
      m_fflag = '0;
    end else begin
      s2 = pipe_q.pop_front();
      pipe_q.push_back(p);
      hist.push_back(s2);
      if (hist.size() > D) void'(hist.pop_front());
      nxt = m_state;
      for (int i = 0; i < N; i++) begin
        all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][i] == m_state[i]) all_diff = 1'b0;
        if (all_diff) nxt[i] = ~m_state[i];
      end
      clr_r   = we_v ? wd_v[8 +: N] : '0;
      clr_f   = we_v ? wd_v[16 +: N] : '0;
      m_rflag = (m_rflag & ~clr_r) | (nxt & ~m_state);
      m_fflag = (m_fflag & ~clr_f) | (~nxt & m_state);
      m_state = nxt;
    end
  endtask

  task automatic step(input logic [N-1:0] p, input logic we_v, input logic [31:0] wd_v,
                      input logic rst_v);
    pins      = p;
    bus_if.WE = we_v;
    bus_if.WD = wd_v;
    rst       = rst_v;
    @(posedge clk);
    model_edge(p, we_v, wd_v, rst_v);
    #1;
    bus_if.WE = 1'b0;
    bus_if.WD = '0;
  endtask

  task automatic do_reset();
    repeat (3) step('0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) begin
      step(5'b11111, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (bus_if.RD !== 32'h0 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: RD=%h irq=%b required RD=0 irq=0", bus_if.RD, irq);
      end
    end
    for (int k = 1; k <= 6; k++) begin
      step(5'b11111, 1'b0, 32'h0, 1'b0);
      if (k < 6) begin
        n_cmp++;
        if (bus_if.RD !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_latency edge %0d: RD=%h required 0", k, bus_if.RD);
        end
      end else begin
        n_cmp++;
        if (bus_if.RD !== 32'h0000_1F1F || irq !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_release: RD=%h irq=%b required 00001f1f/1", bus_if.RD, irq);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int high_cycles;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      step((k < 3) ? 5'b00001 : 5'b00000, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (bus_if.RD !== 32'h0 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch3 step %0d: RD=%h irq=%b required 0/0", k, bus_if.RD, irq);
      end
    end
    high_cycles = 0;
    for (int k = 0; k < 16; k++) begin
      step((k < 4) ? 5'b00001 : 5'b00000, 1'b0, 32'h0, 1'b0);
      if (bus_if.RD[0] === 1'b1) high_cycles++;
    end
    n_cmp++;
    if (high_cycles != 4) begin
      n_fail++;
      $display("FAIL glitch4_width: state high %0d cycles required 4", high_cycles);
    end
    n_cmp++;
    if (bus_if.RD !== 32'h0000_0100 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch4_sticky: RD=%h irq=%b required 00000100/1", bus_if.RD, irq);
    end
  endtask

  task automatic test_bounce();
    logic seq [13];
    int   first_rise;
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    first_rise = 0;
    for (int k = 1; k <= 13; k++) begin
      step({2'b00, seq[k-1], 2'b00}, 1'b0, 32'h0, 1'b0);
      if (first_rise == 0 && bus_if.RD[2] === 1'b1) first_rise = k;
      n_cmp++;
      if (bus_if.RD !== exp_rd()) begin
        n_fail++;
        $display("FAIL bounce_model step %0d: RD=%h required %h", k, bus_if.RD, exp_rd());
      end
    end
    n_cmp++;
    if (first_rise != 11) begin
      n_fail++;
      $display("FAIL bounce_latency: state[2] rose at step %0d required 11", first_rise);
    end
    n_cmp++;
    if (bus_if.RD !== 32'h0000_0404) begin
      n_fail++;
      $display("FAIL bounce_final: RD=%h required 00000404", bus_if.RD);
    end
  endtask

  task automatic test_w1c();
    do_reset();
    repeat (8) step(5'b10101, 1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (bus_if.RD !== 32'h0000_1515) begin
      n_fail++;
      $display("FAIL w1c_setup: RD=%h required 00001515", bus_if.RD);
    end
    step(5'b10101, 1'b1, 32'h0000_0500, 1'b0);
    n_cmp++;
    if (bus_if.RD !== 32'h0000_1015 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_partial: RD=%h irq=%b required 00001015/1", bus_if.RD, irq);
    end
    step(5'b10101, 1'b1, 32'hFFFF_E0FF, 1'b0);
    n_cmp++;
    if (bus_if.RD !== 32'h0000_1015) begin
      n_fail++;
      $display("FAIL w1c_noop: RD=%h required 00001015", bus_if.RD);
    end
    step(5'b10101, 1'b1, 32'h0000_1100, 1'b0);
    n_cmp++;
    if (bus_if.RD !== 32'h0000_0015 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_all: RD=%h irq=%b required 00000015/0", bus_if.RD, irq);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (5) step(5'b00010, 1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (bus_if.RD[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_pre: RD[1]=%b required 0", bus_if.RD[1]);
    end
    step(5'b00010, 1'b1, 32'h0000_0200, 1'b0);
    n_cmp++;
    if (bus_if.RD !== 32'h0000_0202 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_set_wins: RD=%h irq=%b required 00000202/1", bus_if.RD, irq);
    end
    step(5'b00010, 1'b1, 32'h0000_0200, 1'b0);
    n_cmp++;
    if (bus_if.RD !== 32'h0000_0002 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_later_clear: RD=%h irq=%b required 00000002/0", bus_if.RD, irq);
    end
  endtask

  task automatic test_fall();
    logic [31:0] want;
    do_reset();
    repeat (8) step(5'b01000, 1'b0, 32'h0, 1'b0);
    repeat (8) step(5'b00000, 1'b0, 32'h0, 1'b0);
`ifdef DIGITAL_IN_FALL_EDGE_EN
    want = 32'h0008_0800;
`else
    want = 32'h0000_0800;
`endif
    n_cmp++;
    if (bus_if.RD !== want || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_flags: RD=%h irq=%b required %h/1", bus_if.RD, irq, want);
    end
    step(5'b00000, 1'b1, 32'h0008_0000, 1'b0);
    n_cmp++;
    if (bus_if.RD !== 32'h0000_0800 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_clear: RD=%h irq=%b required 00000800/1", bus_if.RD, irq);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] p;
    int           hold;
    logic         we_v, rst_v;
    logic [31:0]  wd_v;
    do_reset();
    p    = '0;
    hold = 0;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        p    = N'($urandom);
        hold = $urandom_range(1, 7);
      end
      hold--;
      we_v  = ($urandom_range(0, 3) == 0);
      wd_v  = $urandom;
      rst_v = ($urandom_range(0, 199) == 0);
      step(p, we_v, wd_v, rst_v);
      n_cmp++;
      if (bus_if.RD !== exp_rd() || irq !== exp_irq()) begin
        n_fail++;
        $display("FAIL random cycle %0d: RD=%h irq=%b required %h/%b", k, bus_if.RD, irq,
                 exp_rd(), exp_irq());
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    pins      = '0;
    bus_if.WE = 1'b0;
    bus_if.WD = '0;
    test_reset();
    test_glitch();
    test_bounce();
    test_w1c();
    test_simultaneous();
    test_fall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
